// File: rtl/soc_bus_pkg.sv
// Shared bus definitions for the SoC memory path: default widths,
// starvation-counter sizing and the master identifiers used by the arbiter.
package soc_bus_pkg;

    localparam int DEFAULT_ADDR_W   = 32;
    localparam int DEFAULT_DATA_W   = 32;
    localparam int DEFAULT_MAX_WAIT = 4;

    // Wide enough for the largest allowed wait limit (7).
    localparam int WAIT_CNT_W = 3;

    // Master identifiers; CPU is master 0, VGA fetch is master 1.
    typedef enum logic {
        MST_CPU = 1'b0,
        MST_VGA = 1'b1
    } master_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Starvation counter for the low-priority master. Counts consecutive cycles
// in which the master requests but is denied, and raises force_grant once
// the count reaches max_wait so the arbiter hands it the bus.
module arb_starve_cnt
    import soc_bus_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  gnt,
    input  logic [WAIT_CNT_W-1:0] max_wait,
    output logic                  force_grant
);

    logic [WAIT_CNT_W-1:0] wait_cnt;

    // Saturating count of denied cycles; any grant or idle cycle restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (!req || gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // The override depends only on registered state and the live request.
    assign force_grant = req && (wait_cnt == max_wait);

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-ported memory. The VGA fetch
// master (m1) normally wins, but the CPU (m0) is forced through after
// MAX_WAIT consecutive denied cycles. Grants are combinational so one access
// can issue every cycle; read responses are routed back one cycle later to
// whichever master owned the read.
module mem_arbiter
    import soc_bus_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_CODE = WAIT_CNT_W'(MAX_WAIT);

    logic    m0_force;
    logic    m0_win;
    logic    m1_win;
    logic    rsp_read;
    master_e rsp_owner;

    arb_starve_cnt u_starve (
        .clk         (clk),
        .reset       (reset),
        .req         (m0_req),
        .gnt         (m0_gnt),
        .max_wait    (MAX_WAIT_CODE),
        .force_grant (m0_force)
    );

    // Pick a winner and steer its request fields onto the memory port;
    // everything is held at zero while reset is asserted or nobody asks.
    always_comb begin
        m0_win    = 1'b0;
        m1_win    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            if (m0_req && (!m1_req || m0_force)) begin
                m0_win = 1'b1;
            end else if (m1_req) begin
                m1_win = 1'b1;
            end
        end
        if (m0_win) begin
            mem_en    = 1'b1;
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (m1_win) begin
            mem_en    = 1'b1;
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    assign m0_gnt = m0_win;
    assign m1_gnt = m1_win;

    // Remember who issued this cycle's access and whether it was a read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_read  <= 1'b0;
            rsp_owner <= MST_CPU;
        end else begin
            rsp_read  <= mem_en && !mem_we;
            rsp_owner <= m1_win ? MST_VGA : MST_CPU;
        end
    end

    // Route the returning read data to its owner only; the other side sees zero.
    always_comb begin
        m0_rvalid = rsp_read && (rsp_owner == MST_CPU);
        m1_rvalid = rsp_read && (rsp_owner == MST_VGA);
        m0_rdata  = m0_rvalid ? mem_rdata : '0;
        m1_rdata  = m1_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a small memory responder, a transaction-level
// model checked every cycle, and directed scenarios with literal expectations.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;

    typedef struct {
        bit            owner;
        logic [DW-1:0] data;
    } rsp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] sim_mem [1024];
    bit            sim_written [1024];
    logic [DW-1:0] exp_mem [1024];
    bit            exp_written [1024];
    rsp_t          rsp_q [$];
    int            denied_run = 0;
    int            checks = 0;
    int            failures = 0;
    int            m0_rv_count = 0;
    int            m1_rv_count = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Power-on memory contents: 0x10 holds a marker, the rest a pattern.
    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : (32'hA500_0000 ^ a);
    endfunction

    function automatic logic [DW-1:0] sim_word(input logic [AW-1:0] a);
        return sim_written[a[11:2]] ? sim_mem[a[11:2]] : init_word(a);
    endfunction

    function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] a);
        return exp_written[a[11:2]] ? exp_mem[a[11:2]] : init_word(a);
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    endtask

    task automatic apply_stimulus(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                  input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        @(posedge clk);
        #1;
        drive(r0, w0, a0, d0, r1, w1, a1, d1);
    endtask

    task automatic wait_mid();
        @(negedge clk);
        #1;
    endtask

    // Memory responder: writes land at the edge, read data appears one cycle later.
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            sim_mem[mem_addr[11:2]]     <= mem_wdata;
            sim_written[mem_addr[11:2]] <= 1'b1;
        end
        mem_rdata <= (mem_en && !mem_we) ? sim_word(mem_addr) : 32'h0BAD_F00D;
    end

    // Reset wipes any outstanding response and the starvation history.
    initial begin
        forever begin
            @(posedge reset);
            rsp_q.delete();
            denied_run = 0;
        end
    end

    // Transaction-level model and per-cycle comparison of every output.
    initial begin : model
        logic          e0, e1, ewe, v0, v1;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed, d0, d1;
        rsp_t          r;
        forever begin
            @(negedge clk);
            e0 = 1'b0; e1 = 1'b0; ewe = 1'b0; v0 = 1'b0; v1 = 1'b0;
            ea = '0; ed = '0; d0 = '0; d1 = '0;
            if (reset) begin
                rsp_q.delete();
                denied_run = 0;
            end else begin
                if (m0_req && (!m1_req || denied_run >= MW)) e0 = 1'b1;
                else if (m1_req) e1 = 1'b1;
                if (e0) begin
                    ewe = m0_we; ea = m0_addr; ed = m0_wdata;
                end else if (e1) begin
                    ewe = m1_we; ea = m1_addr; ed = m1_wdata;
                end
                if (rsp_q.size() > 0) begin
                    r = rsp_q.pop_front();
                    if (r.owner == 1'b0) begin v0 = 1'b1; d0 = r.data; end
                    else begin v1 = 1'b1; d1 = r.data; end
                end
            end
            check_output("m0_gnt", 64'(m0_gnt), 64'(e0));
            check_output("m1_gnt", 64'(m1_gnt), 64'(e1));
            check_output("mem_en", 64'(mem_en), 64'(e0 | e1));
            check_output("mem_we", 64'(mem_we), 64'(ewe));
            check_output("mem_addr", 64'(mem_addr), 64'(ea));
            check_output("mem_wdata", 64'(mem_wdata), 64'(ed));
            check_output("m0_rvalid", 64'(m0_rvalid), 64'(v0));
            check_output("m1_rvalid", 64'(m1_rvalid), 64'(v1));
            check_output("m0_rdata", 64'(m0_rdata), 64'(d0));
            check_output("m1_rdata", 64'(m1_rdata), 64'(d1));
            if (m0_rvalid) m0_rv_count++;
            if (m1_rvalid) m1_rv_count++;
            if (!reset) begin
                denied_run = (m0_req && !e0) ? denied_run + 1 : 0;
                if (e0 || e1) begin
                    if (ewe) begin
                        exp_mem[ea[11:2]]     = ed;
                        exp_written[ea[11:2]] = 1'b1;
                    end else begin
                        r.owner = e1;
                        r.data  = exp_word(ea);
                        rsp_q.push_back(r);
                    end
                end
            end
        end
    end

    // Directed scenarios with hand-computed expectations.
    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        // Single CPU read straight out of reset.
        drive(1'b1, 1'b0, 32'h10, '0, 1'b0, 1'b0, '0, '0);
        wait_mid();
        check_output("lit_m0_read_gnt", 64'(m0_gnt), 64'd1);
        check_output("lit_m0_read_addr", 64'(mem_addr), 64'h10);
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        wait_mid();
        check_output("lit_m0_read_rvalid", 64'(m0_rvalid), 64'd1);
        check_output("lit_m0_read_rdata", 64'(m0_rdata), 64'hDEADBEEF);

        // Simultaneous requests: VGA first, CPU next cycle.
        apply_stimulus(1'b1, 1'b0, 32'h20, '0, 1'b1, 1'b0, 32'h40, '0);
        wait_mid();
        check_output("lit_tie_m1_gnt", 64'(m1_gnt), 64'd1);
        check_output("lit_tie_m0_gnt", 64'(m0_gnt), 64'd0);
        check_output("lit_tie_addr", 64'(mem_addr), 64'h40);
        apply_stimulus(1'b1, 1'b0, 32'h20, '0, 1'b0, 1'b0, '0, '0);
        wait_mid();
        check_output("lit_tie_m1_rvalid", 64'(m1_rvalid), 64'd1);
        check_output("lit_tie_m1_rdata", 64'(m1_rdata), 64'hA500_0040);
        check_output("lit_tie_m0_late_gnt", 64'(m0_gnt), 64'd1);
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        wait_mid();
        check_output("lit_tie_m0_rdata", 64'(m0_rdata), 64'hA500_0020);

        // Starvation override: CPU forced through on its fifth request cycle.
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b1, 1'b0, (i == 5) ? 32'h28 : 32'h24, '0, 1'b1, 1'b0, 32'h44, '0);
            wait_mid();
            check_output($sformatf("lit_starve_m0_gnt_c%0d", i), 64'(m0_gnt), (i == 4) ? 64'd1 : 64'd0);
            check_output($sformatf("lit_starve_m1_gnt_c%0d", i), 64'(m1_gnt), (i == 4) ? 64'd0 : 64'd1);
        end
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);

        // Write then read back the same word on back-to-back cycles.
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h80, 32'h1234);
        wait_mid();
        check_output("lit_wr_mem_we", 64'(mem_we), 64'd1);
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h80, '0);
        wait_mid();
        check_output("lit_rd_mem_we", 64'(mem_we), 64'd0);
        check_output("lit_wr_no_rvalid", 64'(m1_rvalid), 64'd0);
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        wait_mid();
        check_output("lit_rd_m1_rvalid", 64'(m1_rvalid), 64'd1);
        check_output("lit_rd_m1_rdata", 64'(m1_rdata), 64'h1234);

        // Reset pulse between a granted read and its response.
        apply_stimulus(1'b1, 1'b0, 32'h30, '0, 1'b0, 1'b0, '0, '0);
        wait_mid();
        check_output("lit_rst_pre_gnt", 64'(m0_gnt), 64'd1);
        reset = 1'b1;
        #1;
        check_output("lit_rst_outputs_zero",
                     64'(|{m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
                           mem_en, mem_we, mem_addr, mem_wdata}), 64'd0);
        m0_req = 1'b0;
        #1;
        reset = 1'b0;
        wait_mid();
        check_output("lit_rst_no_rvalid", 64'(m0_rvalid), 64'd0);

        // Alternating reads: one response per cycle, eight per master.
        @(posedge clk);
        #1;
        m0_rv_count = 0;
        m1_rv_count = 0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (i % 2 == 0) drive(1'b1, 1'b0, 32'h100 + 32'(4 * i), '0, 1'b0, 1'b0, '0, '0);
            else            drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h200 + 32'(4 * i), '0);
        end
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        wait_mid();
        check_output("lit_alt_m0_count", 64'(m0_rv_count), 64'd8);
        check_output("lit_alt_m1_count", 64'(m1_rv_count), 64'd8);

        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a run that never reaches its summary.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
